chacha_block_ctrl: RTL

Sequencing controller for the ChaCha20 block function. It loads key, nonce and block counter into a 16-word working state. It then drives four quarter-round instances per cycle, alternating column and diagonal rounds, and applies the final feed-forward addition. The 512-bit keystream block is presented on a valid/ready output. It sits between the cipher front end, which supplies key, nonce and counter, and the XOR/stream stage that consumes keystream.

---
 rtl/chacha_block_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/chacha_block_ctrl.sv
// ChaCha block-function sequencer: load state, run ROUNDS rounds, feed-forward, present keystream on valid/ready.
// Optional feature macro CHACHA_CTR_AUTOINC_EN adds an internal block counter bumped on every output handshake.
module chacha_block_ctrl #(
  parameter int ROUNDS = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  ctr_in,
  input  logic         ctr_load,
  output logic         busy,
  output logic         ks_valid,
  input  logic         ks_ready,
  output logic [511:0] ks_out,
  output logic [31:0]  ctr_out
);
  typedef logic [15:0][31:0] state_t;
  typedef logic [3:0][31:0]  quad_t;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, OUT} fsm_t;

  localparam int              RC_W    = $clog2(ROUNDS);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(ROUNDS - 1);
  localparam logic [127:0]    SIGMA   = 128'h6b206574_79622d32_3320646e_61707865;

  generate
    if (ROUNDS != 8 && ROUNDS != 12 && ROUNDS != 20) begin : g_bad_rounds
      $error("chacha_block_ctrl: ROUNDS must be 8, 12 or 20");
    end
  endgenerate

  function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Quad packs one quarter-round operand set as {d, c, b, a}.
  function automatic quad_t qr(input quad_t v);
    logic [31:0] a, b, c, d;
    {d, c, b, a} = v;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {d, c, b, a};
  endfunction

  function automatic state_t do_round(input state_t s, input logic diag);
    state_t r;
    if (!diag) begin
      {r[12], r[8],  r[4], r[0]} = qr({s[12], s[8],  s[4], s[0]});
      {r[13], r[9],  r[5], r[1]} = qr({s[13], s[9],  s[5], s[1]});
      {r[14], r[10], r[6], r[2]} = qr({s[14], s[10], s[6], s[2]});
      {r[15], r[11], r[7], r[3]} = qr({s[15], s[11], s[7], s[3]});
    end else begin
      {r[15], r[10], r[5], r[0]} = qr({s[15], s[10], s[5], s[0]});
      {r[12], r[11], r[6], r[1]} = qr({s[12], s[11], s[6], s[1]});
      {r[13], r[8],  r[7], r[2]} = qr({s[13], s[8],  s[7], s[2]});
      {r[14], r[9],  r[4], r[3]} = qr({s[14], s[9],  s[4], s[3]});
    end
    return r;
  endfunction

  fsm_t            state_q, state_d;
  logic [RC_W-1:0] rc_q, rc_d;
  logic            busy_q, busy_d;
  logic            ks_valid_q, ks_valid_d;
  state_t          ks_q, ks_d;
  logic [31:0]     ctr_out_q, ctr_out_d;
  state_t          work_q, work_d;
  state_t          saved_q, saved_d;
  state_t          init_w;
  state_t          sum_w;
  logic [31:0]     ctr_sel;

`ifdef CHACHA_CTR_AUTOINC_EN
  logic [31:0] cnt_q, cnt_d;
  assign ctr_sel = (start && ctr_load) ? ctr_in : cnt_q;
`else
  logic unused_ctr_load;
  assign unused_ctr_load = ctr_load;
  assign ctr_sel = ctr_in;
`endif

  assign init_w = {nonce, ctr_sel, key, SIGMA};

  for (genvar g = 0; g < 16; g++) begin : g_feed_fwd
    assign sum_w[g] = work_q[g] + saved_q[g];
  end

  always_comb begin
    // NOTE: every _d defaults to its _q so no path through the case leaves it unassigned and infers a latch.
    state_d    = state_q;
    rc_d       = rc_q;
    busy_d     = busy_q;
    ks_valid_d = ks_valid_q;
    ks_d       = ks_q;
    ctr_out_d  = ctr_out_q;
    work_d     = work_q;
    saved_d    = saved_q;
`ifdef CHACHA_CTR_AUTOINC_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        work_d    = init_w;
        saved_d   = init_w;
        rc_d      = '0;
        ctr_out_d = ctr_sel;
        busy_d    = 1'b1;
        state_d   = ROUND;
      end
      ROUND: begin
        work_d = do_round(work_q, rc_q[0]);
        rc_d   = rc_q + 1'b1;
        if (rc_q == RC_LAST) state_d = FINAL;
      end
      FINAL: begin
        ks_d       = sum_w;
        ks_valid_d = 1'b1;
        state_d    = OUT;
      end
      OUT: if (ks_ready) begin
        ks_valid_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = IDLE;
`ifdef CHACHA_CTR_AUTOINC_EN
        cnt_d      = ctr_out_q + 32'd1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rc_q       <= '0;
      busy_q     <= 1'b0;
      ks_valid_q <= 1'b0;
      ks_q       <= '0;
      ctr_out_q  <= '0;
`ifdef CHACHA_CTR_AUTOINC_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rc_q       <= rc_d;
      busy_q     <= busy_d;
      ks_valid_q <= ks_valid_d;
      ks_q       <= ks_d;
      ctr_out_q  <= ctr_out_d;
`ifdef CHACHA_CTR_AUTOINC_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // NOTE: working and saved state are left unreset; they are always reloaded on start before being read.
  always_ff @(posedge clk) begin
    work_q  <= work_d;
    saved_q <= saved_d;
  end

  assign busy     = busy_q;
  assign ks_valid = ks_valid_q;
  assign ks_out   = ks_q;
  assign ctr_out  = ctr_out_q;

endmodule
